fp_div_mant: RTL
================

FP_DIV_MANT -- requirements
Module: fp_div_mant

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  operand bundle valid.
REQ-005 in_ready  output  1  block can accept a bundle; high only in IDLE.
REQ-006 dividend  input  32  FP32 dividend.
REQ-007 divisor  input  32  FP32 divisor.
REQ-008 exp_in  input  8  biased quotient exponent from upstream fp_div_exp (exp_a - exp_b + bias), used verbatim.
REQ-009 out_valid  output  1  result valid; held until accepted.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 result  output  32  packed FP32 quotient.
REQ-012 div_by_zero  output  1  flag qualified by out_valid.
REQ-013 invalid  output  1  flag qualified by out_valid.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, ROUND, DONE.
REQ-015 Accept handshake: in_valid & in_ready at a rising edge; at that edge capture sign = dividend[31]^divisor[31], exp_in, and 24-bit significands ma = {exp!=0, frac}, mb likewise.
REQ-016 Special cases, decided at accept, SHALL skip CALC/ROUND and enter DONE on the accept edge (out_valid high one cycle later).
- Either exponent 8'hFF, or both operands zero: result 32'h7FC00000, invalid=1.
- Divisor zero with dividend nonzero: result {sign,8'hFF,23'h0}, div_by_zero=1.
- Dividend zero with divisor nonzero: result {sign,31'h0}.
- Precedence is in the listed order.
REQ-017 Otherwise SHALL enter CALC with 25-bit remainder R=ma, quotient Q=0, and 5-bit counter=0.
REQ-018 Each CALC cycle: if R>=mb then qbit=1 and R=R-mb, else qbit=0; then R=R<<1, Q={Q[24:0],qbit}, counter+1.
REQ-019 Exactly 26 CALC cycles (counter 0..25) SHALL complete before transition to ROUND.
REQ-020 ROUND normalization:
- If Q[25]=1: m=Q[24:2], g=Q[1], s=Q[0]|(R!=0), e=exp_in.
- Else: m=Q[23:1], g=Q[0], s=(R!=0), e=exp_in-1 (mod 256).
REQ-021 Rounding SHALL be round-to-nearest-even: increment m if g&(s|m[0]).
REQ-022 If the increment overflows m (all ones), m SHALL become 0 and e SHALL become e+1 (mod 256).
REQ-023 ROUND SHALL register result={sign,e,m} with both flags 0, then go to DONE.
REQ-024 Latency: out_valid SHALL rise 28 clocks after the accept edge for the normal path and 1 clock after it for special cases.
REQ-025 In DONE: out_valid=1 and result/flags stable; on out_valid&out_ready SHALL return to IDLE.
- No new bundle is accepted in that same cycle.
REQ-026 Exponent overflow, underflow and denormal outputs are out of scope.
- Exponent arithmetic wraps modulo 256.
- No saturation is performed.
REQ-027 Inputs SHALL be ignored outside the accept edge; operand changes during CALC SHALL have no effect.

Reset
REQ-028 rst SHALL force IDLE from any state, including mid-CALC and DONE, on the next edge.
REQ-029 After reset: in_ready=1, out_valid=0, result=0, div_by_zero=0, invalid=0, counter=0, R=0, Q=0.
REQ-030 rst SHALL dominate a coincident handshake; any in-flight operation is discarded.

Verification
REQ-031 6.0/2.0: 40C00000 / 40000000, exp_in=8'h80 -> result 40400000, flags 0, out_valid 28 clocks after accept.
REQ-032 1.0/3.0: 3F800000 / 40400000, exp_in=8'h7E -> Q[25]=0 path, result 3EAAAAAB (rounded up).
REQ-033 -1.0/3.0: BF800000 / 40400000, exp_in=8'h7E -> result BEAAAAAB.
REQ-034 5.0/0: 40A00000 / 00000000 -> result 7F800000, div_by_zero=1, out_valid 1 clock after accept.
- 0/0 -> 7FC00000, invalid=1.
REQ-035 Backpressure: out_ready held low 10 clocks in DONE -> result stable, in_ready=0, in_valid ignored.
- Release -> IDLE on the next edge.
REQ-036 rst asserted at CALC counter=10 -> next clock in_ready=1, out_valid=0.
- A fresh 6.0/2.0 then completes correctly.

Source files
------------

// File: rtl/fp_div_mant_if.sv
// Operand/result handshake bundle for the FP32 mantissa divider.
// The master side presents operands and accepts results.
// The slave side is the divider itself.
interface fp_div_mant_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [7:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        div_by_zero;
  logic        invalid;

  modport master (
    output in_valid, dividend, divisor, exp_in, out_ready,
    input  in_ready, out_valid, result, div_by_zero, invalid
  );

  modport slave (
    input  in_valid, dividend, divisor, exp_in, out_ready,
    output in_ready, out_valid, result, div_by_zero, invalid
  );
endinterface

// File: rtl/fp_div_mant.sv
// FP32 significand divider.
// A restoring divider produces one quotient bit per cycle, 26 bits in total.
// The quotient is then normalised and rounded to nearest-even, and the packed
// result is held until downstream accepts it.
// The biased exponent comes from upstream and is only adjusted here for
// normalisation and rounding carry.
// NaN, infinity and zero operands bypass the iteration entirely.
module fp_div_mant (
  input  logic          clk,
  input  logic          rst,
  fp_div_mant_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [4:0]  LAST_STEP = 5'd25;

  state_t      state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] result_q;
  logic        dbz_q;
  logic        inv_q;
  logic        sign_q;
  logic [7:0]  exp_q;
  logic [23:0] mb_q;
  logic [24:0] rem_q;
  logic [25:0] quo_q;
  logic [4:0]  cnt_q;

  // Operand decode, looked at only on the accept edge.
  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic [23:0] ma_d;
  logic [23:0] mb_d;
  logic        sign_d;
  logic        a_zero;
  logic        b_zero;
  logic        is_invalid;
  logic        is_dbz;

  // One restoring-division step.
  logic        rem_ge;
  logic [24:0] rem_sub;
  logic [24:0] rem_d;
  logic [25:0] quo_d;

  // Normalise and round.
  logic [22:0] m_pre;
  logic        g_bit;
  logic        s_bit;
  logic [7:0]  e_pre;
  logic        round_up;
  logic [23:0] m_sum;
  logic [22:0] m_fin;
  logic [7:0]  e_fin;

  assign exp_a  = bus.dividend[30:23];
  assign exp_b  = bus.divisor[30:23];
  assign ma_d   = {(exp_a != 8'h00), bus.dividend[22:0]};
  assign mb_d   = {(exp_b != 8'h00), bus.divisor[22:0]};
  assign sign_d = bus.dividend[31] ^ bus.divisor[31];
  assign a_zero = (bus.dividend[30:0] == 31'h0);
  assign b_zero = (bus.divisor[30:0] == 31'h0);

  // Special-case precedence: NaN/Inf operands or 0/0 first, then x/0.
  assign is_invalid = (exp_a == 8'hFF) || (exp_b == 8'hFF) || (a_zero && b_zero);
  assign is_dbz     = b_zero && !a_zero;

  // Compare/subtract/shift for one quotient bit.
  // The remainder stays below 2*mb, so the shifted value always fits in 25 bits.
  always_comb begin
    rem_ge  = (rem_q >= {1'b0, mb_q});
    rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_d   = rem_sub << 1;
    quo_d   = {quo_q[24:0], rem_ge};
  end

  // Pick the 23 fraction bits from the quotient depending on where its leading one
  // sits, then round to nearest-even.
  // A carry out of the mantissa bumps the exponent.
  always_comb begin
    if (quo_q[25]) begin
      m_pre = quo_q[24:2];
      g_bit = quo_q[1];
      s_bit = quo_q[0] | (rem_q != 25'h0);
      e_pre = exp_q;
    end else begin
      m_pre = quo_q[23:1];
      g_bit = quo_q[0];
      s_bit = (rem_q != 25'h0);
      e_pre = exp_q - 8'd1;
    end
    round_up = g_bit & (s_bit | m_pre[0]);
    m_sum    = {1'b0, m_pre} + {23'h0, round_up};
    m_fin    = m_sum[22:0];
    e_fin    = e_pre + {7'h0, m_sum[23]};
  end

  // Control FSM plus datapath registers.
  // out_valid rises one cycle after DONE is entered and is held until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= 32'h0;
      dbz_q       <= 1'b0;
      inv_q       <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= 8'h0;
      mb_q        <= 24'h0;
      rem_q       <= 25'h0;
      quo_q       <= 26'h0;
      cnt_q       <= 5'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            sign_q     <= sign_d;
            exp_q      <= bus.exp_in;
            mb_q       <= mb_d;
            rem_q      <= {1'b0, ma_d};
            quo_q      <= 26'h0;
            cnt_q      <= 5'h0;
            if (is_invalid) begin
              result_q <= QNAN;
              inv_q    <= 1'b1;
              dbz_q    <= 1'b0;
              state_q  <= DONE;
            end else if (is_dbz) begin
              result_q <= {sign_d, 8'hFF, 23'h0};
              inv_q    <= 1'b0;
              dbz_q    <= 1'b1;
              state_q  <= DONE;
            end else if (a_zero) begin
              result_q <= {sign_d, 31'h0};
              inv_q    <= 1'b0;
              dbz_q    <= 1'b0;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
          end
        end

        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_STEP) begin
            state_q <= ROUND;
          end
        end

        ROUND: begin
          result_q <= {sign_q, e_fin, m_fin};
          inv_q    <= 1'b0;
          dbz_q    <= 1'b0;
          state_q  <= DONE;
        end

        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.invalid     = inv_q;

endmodule
